// File: rtl/gtrg_dav_fifo_n.sv
// Trigger/DAV FIFO: delays L1A push and DAV channels, captures {scope, dav, bx} per delayed push.
// Latency: DPUSH = PUSH + PUSHDLY+1 clocks; read data appears 1 clock after an accepted pop.
// Backpressure: none upstream; push on full without pop is dropped (OVFL), pop on empty is ignored (UNFL).
module gtrg_dav_fifo_n #(
   parameter int NCH   = 5,
   parameter int AW    = 10,
   parameter int DLYW  = 4,
   parameter int SCOPE = 5,
   parameter int BXMAX = 3563,
   parameter int TMR   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             bc0,
   input  logic [NCH-1:0]   dav,
   input  logic [NCH-1:0]   kill,
   input  logic [DLYW-1:0]  pushdly,
   input  logic [DLYW-1:0]  davdly,
   input  logic [AW:0]      afthr,
   input  logic             errclr,
   output logic             dpush,
   output logic             empty_b,
   output logic             full,
   output logic             afull,
   output logic [AW:0]      occ,
   output logic             dout_val,
   output logic [11:0]      dout_bx,
   output logic [NCH-1:0]   dout_dav,
   output logic [SCOPE-1:0] dout_scp,
   output logic             ovfl,
   output logic             unfl,
   output logic [7:0]       errcnt
);

   localparam int PD    = 2**DLYW;
   localparam int W     = SCOPE + NCH + 12;
   localparam int DEPTH = 2**AW;

   logic [11:0]      bx;
   logic [11:0]      bx_sr  [PD];
   logic [NCH-1:0]   dav_sr [PD];
   logic [NCH-1:0]   dd;
   logic             or_d;
   logic [SCOPE-1:0] scp;
   logic [PD-1:0]    psr_v, psr_nxt;
   logic [AW-1:0]    wp_v, rp_v, wp_nxt, rp_nxt;
   logic             ce_rd, ce_wr, ovfl_ev, unfl_ev;
   logic [W-1:0]     wr_word, rd_q;
   logic [W-1:0]     mem [DEPTH];

   // BX counter: BC0 or reaching BXMAX returns to 0, otherwise count every clock
   always_ff @(posedge clk) begin
      if (rst || bc0 || bx == 12'(BXMAX)) bx <= '0;
      else                                bx <= bx + 12'd1;
   end

   // BX and masked-DAV delay lines; taps are selected by the delay controls
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PD; i++) begin
            bx_sr[i]  <= '0;
            dav_sr[i] <= '0;
         end
      end else begin
         bx_sr[0]  <= bx;
         dav_sr[0] <= dav & ~kill;
         for (int i = 1; i < PD; i++) begin
            bx_sr[i]  <= bx_sr[i-1];
            dav_sr[i] <= dav_sr[i-1];
         end
      end
   end

   assign dd      = dav_sr[davdly];
   assign or_d    = |dd;
   assign dpush   = psr_v[pushdly];
   assign wr_word = {scp, dd, bx_sr[pushdly]};

   // scope bit 0 is the current OR-of-DAV, older samples sit in the history register
   assign scp[0] = or_d;
   generate
      if (SCOPE > 1) begin : g_hist
         logic [SCOPE-2:0] hist;
         // shift the OR-of-DAV history one place per clock
         always_ff @(posedge clk) begin
            if (rst) hist <= '0;
            else     hist <= scp[SCOPE-2:0];
         end
         assign scp[SCOPE-1:1] = hist;
      end
   endgenerate

   assign ce_rd   = pop & empty_b;
   assign ce_wr   = dpush & (~full | ce_rd);
   assign ovfl_ev = dpush & full & ~ce_rd;
   assign unfl_ev = pop & ~empty_b;

   assign psr_nxt = {psr_v[PD-2:0], push};
   assign wp_nxt  = ce_wr ? wp_v + AW'(1) : wp_v;
   assign rp_nxt  = ce_rd ? rp_v + AW'(1) : rp_v;

   generate
      if (TMR != 0) begin : g_tmr
         logic [PD-1:0] psr_c [3];
         logic [AW-1:0] wp_c  [3];
         logic [AW-1:0] rp_c  [3];
         // three copies reload from the voted value each clock so a single upset heals
         always_ff @(posedge clk) begin
            for (int k = 0; k < 3; k++) begin
               if (rst) begin
                  psr_c[k] <= '0;
                  wp_c[k]  <= '0;
                  rp_c[k]  <= '0;
               end else begin
                  psr_c[k] <= psr_nxt;
                  wp_c[k]  <= wp_nxt;
                  rp_c[k]  <= rp_nxt;
               end
            end
         end
         assign psr_v = (psr_c[0] & psr_c[1]) | (psr_c[0] & psr_c[2]) | (psr_c[1] & psr_c[2]);
         assign wp_v  = (wp_c[0] & wp_c[1]) | (wp_c[0] & wp_c[2]) | (wp_c[1] & wp_c[2]);
         assign rp_v  = (rp_c[0] & rp_c[1]) | (rp_c[0] & rp_c[2]) | (rp_c[1] & rp_c[2]);
      end else begin : g_one
         logic [PD-1:0] psr_q;
         logic [AW-1:0] wp_q, rp_q;
         // single-copy push pipeline and FIFO pointers
         always_ff @(posedge clk) begin
            if (rst) begin
               psr_q <= '0;
               wp_q  <= '0;
               rp_q  <= '0;
            end else begin
               psr_q <= psr_nxt;
               wp_q  <= wp_nxt;
               rp_q  <= rp_nxt;
            end
         end
         assign psr_v = psr_q;
         assign wp_v  = wp_q;
         assign rp_v  = rp_q;
      end
   endgenerate

   // occupancy tracks accepted writes minus accepted reads
   always_ff @(posedge clk) begin
      if (rst)                 occ <= '0;
      else if (ce_wr & ~ce_rd) occ <= occ + (AW+1)'(1);
      else if (ce_rd & ~ce_wr) occ <= occ - (AW+1)'(1);
   end

   assign full    = (occ == (AW+1)'(DEPTH));
   assign empty_b = |occ;
   assign afull   = (occ >= afthr);

   // storage array; contents are not cleared by reset
   always_ff @(posedge clk) begin
      if (ce_wr) mem[wp_v] <= wr_word;
   end

   // registered read port; on push+pop at full the old word at rp is read before overwrite
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q     <= '0;
         dout_val <= 1'b0;
      end else begin
         dout_val <= ce_rd;
         if (ce_rd) rd_q <= mem[rp_v];
      end
   end

   assign dout_scp = rd_q[W-1 -: SCOPE];
   assign dout_dav = rd_q[12 +: NCH];
   assign dout_bx  = rd_q[11:0];

   // sticky error flags and saturating error counter; clear wins over a same-cycle error
   always_ff @(posedge clk) begin
      if (rst || errclr) begin
         ovfl   <= 1'b0;
         unfl   <= 1'b0;
         errcnt <= '0;
      end else begin
         if (ovfl_ev) ovfl <= 1'b1;
         if (unfl_ev) unfl <= 1'b1;
         if ((ovfl_ev || unfl_ev) && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_gtrg_dav_fifo_n.sv
// Scoreboard bench for gtrg_dav_fifo_n with AW=3 (8-deep) and default channel/scope sizes.
// Stimulus queues expected read words; a negedge monitor checks every DOUT_VAL pulse.
// Flags, occupancy and DPUSH timing are checked directly after the relevant clock.
module tb_gtrg_dav_fifo_n;

   logic        clk = 1'b0;
   logic        rst, push, pop, bc0, errclr;
   logic [4:0]  dav, kill;
   logic [3:0]  pushdly, davdly;
   logic [3:0]  afthr;
   logic        dpush, empty_b, full, afull, dout_val, ovfl, unfl;
   logic [3:0]  occ;
   logic [11:0] dout_bx;
   logic [4:0]  dout_dav, dout_scp;
   logic [7:0]  errcnt;

   int          nchk = 0;
   int          nerr = 0;
   logic [21:0] q[$];
   logic [21:0] exp_w;
   logic [11:0] mbx = '0;

   gtrg_dav_fifo_n #(.NCH(5), .AW(3), .DLYW(4), .SCOPE(5), .BXMAX(3563), .TMR(0)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .bc0(bc0), .dav(dav), .kill(kill),
      .pushdly(pushdly), .davdly(davdly), .afthr(afthr), .errclr(errclr),
      .dpush(dpush), .empty_b(empty_b), .full(full), .afull(afull), .occ(occ),
      .dout_val(dout_val), .dout_bx(dout_bx), .dout_dav(dout_dav), .dout_scp(dout_scp),
      .ovfl(ovfl), .unfl(unfl), .errcnt(errcnt)
   );

   always #5 clk = ~clk;

   // reference BX counter used to predict the captured BX of generic pushes
   always @(posedge clk) begin
      if (rst || bc0 || mbx == 12'd3563) mbx <= '0;
      else                               mbx <= mbx + 12'd1;
   end

   // monitor: every read pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (dout_val) begin
         nchk++;
         if (q.size() == 0) begin
            nerr++;
            $display("FAIL dout_unexpected got=%h expected=none", {dout_scp, dout_dav, dout_bx});
         end else begin
            exp_w = q.pop_front();
            if ({dout_scp, dout_dav, dout_bx} !== exp_w) begin
               nerr++;
               $display("FAIL dout_word got scp=%b dav=%b bx=%0d expected scp=%b dav=%b bx=%0d",
                        dout_scp, dout_dav, dout_bx, exp_w[21:17], exp_w[16:12], exp_w[11:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic pop_one();
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   // one-cycle DAV pulse, then a push timed so the delayed push lands gap clocks after the delayed DAV
   task automatic dav_push(input logic [4:0] dv, input logic [4:0] kl, input int gap,
                           input logic [4:0] edav, input logic [4:0] escp);
      dav  = dv;
      kill = kl;
      tick();
      dav  = '0;
      kill = '0;
      repeat (1 + gap) tick();
      push = 1'b1;
      q.push_back({escp, edav, mbx});
      tick();
      push = 1'b0;
      tick();
      pop_one();
      tick();
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; bc0 = 1'b0; errclr = 1'b0;
      dav = '0; kill = '0; pushdly = 4'd0; davdly = 4'd0; afthr = 4'd6;
      tick();
      tick();
      // reset state
      check("rst_occ", int'(occ), 0);
      check("rst_empty_b", int'(empty_b), 0);
      check("rst_full", int'(full), 0);
      check("rst_afull", int'(afull), 0);
      check("rst_dpush", int'(dpush), 0);
      check("rst_dout_val", int'(dout_val), 0);
      check("rst_dout_bx", int'(dout_bx), 0);
      check("rst_errs", int'({ovfl, unfl, errcnt}), 0);
      rst = 1'b0;

      // 1: PUSHDLY=3, push at BX=100, DPUSH 4 clocks later
      pushdly = 4'd3;
      bc0 = 1'b1;
      tick();
      bc0 = 1'b0;
      repeat (100) tick();
      push = 1'b1;
      q.push_back({5'd0, 5'd0, 12'd100});
      tick();
      push = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("t1_dpush_%0d", k), int'(dpush), (k == 4) ? 1 : 0);
         if (k < 4) tick();
      end
      tick();
      check("t1_occ", int'(occ), 1);
      pop_one();
      tick();
      check("t1_occ_after_pop", int'(occ), 0);

      // 2: DAV delay and scope capture
      pushdly = 4'd0;
      davdly  = 4'd2;
      dav_push(5'b00100, 5'b00000, 0, 5'b00100, 5'b00001);
      dav_push(5'b00100, 5'b00100, 0, 5'b00000, 5'b00000);
      dav_push(5'b00001, 5'b00000, 2, 5'b00000, 5'b00100);
      davdly = 4'd0;
      repeat (6) tick();

      // 3: fill an 8-deep FIFO, AFTHR=6, then overflow on the 9th
      for (int i = 1; i <= 9; i++) begin
         push = 1'b1;
         if (i <= 8) q.push_back({10'd0, mbx});
         tick();
         push = 1'b0;
         tick();
         check($sformatf("t3_occ_%0d", i), int'(occ), (i < 8) ? i : 8);
         check($sformatf("t3_afull_%0d", i), int'(afull), (i >= 6) ? 1 : 0);
         check($sformatf("t3_full_%0d", i), int'(full), (i >= 8) ? 1 : 0);
         check($sformatf("t3_ovfl_%0d", i), int'(ovfl), (i == 9) ? 1 : 0);
         check($sformatf("t3_errcnt_%0d", i), int'(errcnt), (i == 9) ? 1 : 0);
      end

      // 4: push and pop together on a full FIFO
      push = 1'b1;
      q.push_back({10'd0, mbx});
      tick();
      push = 1'b0;
      pop  = 1'b1;
      tick();
      pop = 1'b0;
      check("t4_occ", int'(occ), 8);
      check("t4_full", int'(full), 1);
      check("t4_errcnt", int'(errcnt), 1);
      repeat (8) begin
         pop_one();
         tick();
      end
      check("t4_occ_drained", int'(occ), 0);
      check("t4_empty_b", int'(empty_b), 0);

      // 5: underflow, clear, clear priority, saturation
      errclr = 1'b1;
      tick();
      errclr = 1'b0;
      check("t5_clr", int'({ovfl, unfl, errcnt}), 0);
      pop_one();
      check("t5_unfl", int'(unfl), 1);
      check("t5_errcnt", int'(errcnt), 1);
      check("t5_ovfl", int'(ovfl), 0);
      check("t5_dout_val", int'(dout_val), 0);
      errclr = 1'b1;
      pop    = 1'b1;
      tick();
      errclr = 1'b0;
      check("t5_clr_priority", int'({unfl, errcnt}), 0);
      repeat (300) tick();
      pop = 1'b0;
      check("t5_sat", int'(errcnt), 255);
      check("t5_unfl_sticky", int'(unfl), 1);
      errclr = 1'b1;
      tick();
      errclr = 1'b0;
      check("t5_clr2", int'({ovfl, unfl, errcnt}), 0);

      // 6a: BX wrap 3563 -> 0, and BC0 at BX=50
      bc0 = 1'b1;
      tick();
      bc0 = 1'b0;
      repeat (3563) tick();
      push = 1'b1;
      q.push_back({10'd0, 12'd3563});
      tick();
      q.push_back({10'd0, 12'd0});
      tick();
      push = 1'b0;
      bc0  = 1'b1;
      tick();
      bc0 = 1'b0;
      repeat (50) tick();
      bc0  = 1'b1;
      push = 1'b1;
      q.push_back({10'd0, 12'd50});
      tick();
      bc0 = 1'b0;
      q.push_back({10'd0, 12'd0});
      tick();
      push = 1'b0;
      tick();
      check("t6_occ", int'(occ), 4);
      repeat (4) begin
         pop_one();
         tick();
      end

      // 6b: reset with a push still in the delay pipeline
      pushdly = 4'd3;
      push = 1'b1;
      tick();
      push = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t6_no_dpush_%0d", k), int'(dpush), 0);
         tick();
      end
      check("t6_rst_occ", int'(occ), 0);
      check("t6_rst_empty_b", int'(empty_b), 0);

      repeat (3) tick();
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
